// File: rtl/power_seq_if.sv
// power_seq_if: start/busy/done handshake and operand/result bundle for power_seq.
// master drives start, A (fp32 base), B (unsigned exponent); slave returns result, flags, busy, done.
interface power_seq_if #(
    parameter int EXP_W = 24
);
    logic             start;
    logic [31:0]      A;
    logic [EXP_W-1:0] B;
    logic [31:0]      result;
    logic             overflow;
    logic             underflow;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  result, overflow, underflow, busy, done
    );

    modport slave (
        input  start, A, B,
        output result, overflow, underflow, busy, done
    );
endinterface

// File: rtl/power_seq.sv
// power_seq: fp32 A^B by square-and-multiply, one exponent bit per clock.
// Ports: CLK, RST (async active-low), bus (power_seq_if.slave: start/A/B in; result/flags/busy/done out).
module power_seq #(
    parameter int EXP_W = 24
) (
    input  logic        CLK,
    input  logic        RST,
    power_seq_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] SPEC = 2'd2;

    localparam logic [30:0] ONE_M = 31'h3F800000;
    localparam logic [30:0] INF_M = 31'h7F800000;
    localparam logic [30:0] NAN_M = 31'h7FC00000;

    logic [1:0]       state;
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] e_shr;
    logic [30:0]      base;
    logic [30:0]      acc;
    logic             sgn;
    logic [31:0]      result_q;
    logic             ovf_q;
    logic             udf_q;
    logic             done_q;
    logic [30:0]      acc_mul;
    logic [30:0]      base_sq;
    logic [30:0]      acc_nxt;
    logic             a_spec;

    // Magnitude-only multiply: truncating, denormals flush to zero.
    function automatic logic [30:0] fmul(input logic [30:0] a, input logic [30:0] b);
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic        a_inf;
        logic        b_inf;
        logic        a_nan;
        logic        b_nan;
        logic        a_zero;
        logic        b_zero;
        logic [47:0] p;
        logic [22:0] m;
        logic [9:0]  es;
        logic [9:0]  eo;
        logic [30:0] r;
        ea     = a[30:23];
        eb     = b[30:23];
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        p      = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        m      = p[47] ? p[46:24] : p[45:23];
        es     = {2'b0, ea} + {2'b0, eb} + {9'b0, p[47]};
        eo     = es - 10'd127;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            r = NAN_M;
        else if (a_inf || b_inf)
            r = INF_M;
        else if (a_zero || b_zero)
            r = 31'd0;
        else if (es >= 10'd382)
            r = INF_M;
        else if (es <= 10'd127)
            r = 31'd0;
        else
            r = {eo[7:0], m};
        return r;
    endfunction

    always_comb begin
        acc_mul = fmul(acc, base);
        base_sq = fmul(base, base);
        acc_nxt = e[0] ? acc_mul : acc;
        e_shr   = e >> 1;
        a_spec  = (bus.B == '0) ||
                  (bus.A[30:23] == 8'hFF) ||
                  (bus.A[30:23] == 8'h00);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            e        <= '0;
            base     <= '0;
            acc      <= ONE_M;
            sgn      <= 1'b0;
            result_q <= {1'b0, ONE_M};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        e     <= bus.B;
                        base  <= bus.A[30:0];
                        acc   <= ONE_M;
                        sgn   <= bus.A[31] & bus.B[0];
                        ovf_q <= 1'b0;
                        udf_q <= 1'b0;
                        state <= a_spec ? SPEC : RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    base <= base_sq;
                    e    <= e_shr;
                    // Flags come only from acc, so a discarded base overflow is harmless.
                    if (e_shr == '0) begin
                        result_q <= {sgn, acc_nxt};
                        ovf_q    <= (acc_nxt == INF_M);
                        udf_q    <= (acc_nxt == 31'd0);
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                SPEC: begin
                    // B==0 wins over every operand class, NaN included.
                    if (e == '0)
                        result_q <= {1'b0, ONE_M};
                    else if ((base[30:23] == 8'hFF) && (base[22:0] != 23'd0))
                        result_q <= {1'b0, NAN_M};
                    else if (base[30:23] == 8'hFF)
                        result_q <= {sgn, INF_M};
                    else
                        result_q <= {sgn, 31'd0};
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_power_seq.sv
// tb_power_seq: randomized and directed checks of power_seq against a behavioural model.
// Model works on (mantissa, exponent) integers with sticky inf/zero, independent of fp32 encoding.
module tb_power_seq;
    localparam int EXP_W = 24;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    power_seq_if #(.EXP_W(EXP_W)) bus ();

    power_seq #(.EXP_W(EXP_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit     nan;
        bit     inf;
        bit     zero;
        longint m;
        int     x;
    } num_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value = m * 2^x, m in [2^23, 2^24).
    function automatic num_t decode(input logic [31:0] a);
        num_t r;
        r      = '{default: 0};
        r.m    = longint'({1'b1, a[22:0]});
        r.x    = int'(a[30:23]) - 150;
        return r;
    endfunction

    function automatic num_t nmul(input num_t p, input num_t q);
        num_t r;
        r = '{default: 0};
        if (p.nan || q.nan || (p.inf && q.zero) || (p.zero && q.inf))
            r.nan = 1;
        else if (p.inf || q.inf)
            r.inf = 1;
        else if (p.zero || q.zero)
            r.zero = 1;
        else begin
            r.m = p.m * q.m;
            r.x = p.x + q.x;
            while (r.m >= (64'd1 << 24)) begin
                r.m = r.m >> 1;
                r.x = r.x + 1;
            end
            if (r.x + 150 >= 255)
                r.inf = 1;
            else if (r.x + 150 <= 0)
                r.zero = 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] encode(input num_t v);
        logic [31:0] w;
        logic [7:0]  bx;
        if (v.nan)
            w = 32'h7FC00000;
        else if (v.inf)
            w = 32'h7F800000;
        else if (v.zero)
            w = 32'h0;
        else begin
            bx = 8'(v.x + 150);
            w  = {1'b0, bx, v.m[22:0]};
        end
        return w;
    endfunction

    task automatic ref_pow(input logic [31:0] a, input logic [EXP_W-1:0] b,
                           output logic [31:0] res, output logic ovf,
                           output logic udf, output int lat);
        num_t             acc;
        num_t             base;
        logic [EXP_W-1:0] bb;
        logic [31:0]      mag;
        logic             sg;
        sg  = a[31] & b[0];
        ovf = 1'b0;
        udf = 1'b0;
        lat = 1;
        if (b == '0)
            res = 32'h3F800000;
        else if (a[30:23] == 8'hFF && a[22:0] != 0)
            res = 32'h7FC00000;
        else if (a[30:23] == 8'hFF)
            res = {sg, 31'h7F800000};
        else if (a[30:23] == 8'h00)
            res = {sg, 31'h0};
        else begin
            acc  = decode(32'h3F800000);
            base = decode(a);
            bb   = b;
            lat  = 0;
            while (bb != 0) begin
                if (bb[0])
                    acc = nmul(acc, base);
                base = nmul(base, base);
                bb   = bb >> 1;
                lat++;
            end
            mag = encode(acc);
            res = {sg, mag[30:0]};
            ovf = acc.inf;
            udf = acc.zero;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [EXP_W-1:0] b);
        logic [31:0] er;
        logic        eo;
        logic        eu;
        int          el;
        int          n;
        ref_pow(a, b, er, eo, eu, el);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge CLK);
        #1;
        check({tag, "_done_lo"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_busy_hi"}, {31'b0, bus.busy}, 32'd1);
        bus.start = 1'($urandom_range(0, 1));
        bus.A     = $urandom;
        bus.B     = EXP_W'($urandom);
        n = 0;
        while (n < EXP_W + 4) begin
            @(posedge CLK);
            #1;
            n++;
            if (bus.done)
                break;
            bus.start = 1'($urandom_range(0, 1));
            bus.A     = $urandom;
            bus.B     = EXP_W'($urandom);
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, n, el);
        check({tag, "_res"}, bus.result, er);
        check({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, eo});
        check({tag, "_udf"}, {31'b0, bus.underflow}, {31'b0, eu});
        check({tag, "_busy_lo"}, {31'b0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] a;
        int          k;
        a = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6)
            a[30:23] = 8'($urandom_range(120, 134));
        else if (k == 6)
            a[30:23] = 8'hFF;
        else if (k == 7)
            a[30:23] = 8'h00;
        return a;
    endfunction

    initial begin
        logic [EXP_W-1:0] rb;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", bus.result, 32'h3F800000);
        check("rst_flags", {30'b0, bus.overflow, bus.underflow}, 32'd0);
        check("rst_hs", {30'b0, bus.busy, bus.done}, 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        run_op("pow2_10", 32'h40000000, 24'd10);
        check("pow2_10_val", bus.result, 32'h44800000);
        run_op("neg3_3", 32'hC0400000, 24'd3);
        check("neg3_3_val", bus.result, 32'hC1D80000);
        run_op("neg3_2", 32'hC0400000, 24'd2);
        check("neg3_2_val", bus.result, 32'h41100000);
        run_op("b0", 32'h40A00000, 24'd0);
        check("b0_val", bus.result, 32'h3F800000);
        run_op("nan", 32'h7FC00001, 24'd5);
        check("nan_val", bus.result, 32'h7FC00000);
        run_op("nzero", 32'h80000000, 24'd3);
        check("nzero_val", bus.result, 32'h80000000);
        run_op("ninf", 32'hFF800000, 24'd2);
        check("ninf_val", bus.result, 32'h7F800000);
        check("ninf_ovf", {31'b0, bus.overflow}, 32'd0);
        run_op("ovf", 32'h40000000, 24'd200);
        check("ovf_val", bus.result, 32'h7F800000);
        check("ovf_flag", {31'b0, bus.overflow}, 32'd1);
        run_op("udf", 32'h3F000000, 24'd200);
        check("udf_val", bus.result, 32'h00000000);
        check("udf_flag", {31'b0, bus.underflow}, 32'd1);
        run_op("nan_b0", 32'h7FC00001, 24'd0);
        check("nan_b0_val", bus.result, 32'h3F800000);
        run_op("big_base_b1", 32'h7E000000, 24'd1);
        check("big_base_b1_ovf", {31'b0, bus.overflow}, 32'd0);
        run_op("one_max", 32'h3F800000, {EXP_W{1'b1}});
        check("one_max_val", bus.result, 32'h3F800000);

        bus.start = 1'b1;
        bus.A     = 32'h40000000;
        bus.B     = 24'hFFFFFF;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("mid_rst_result", bus.result, 32'h3F800000);
        check("mid_rst_flags", {30'b0, bus.overflow, bus.underflow}, 32'd0);
        check("mid_rst_hs", {30'b0, bus.busy, bus.done}, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        run_op("post_rst", 32'h40000000, 24'd10);
        check("post_rst_val", bus.result, 32'h44800000);

        for (int i = 0; i < 200; i++) begin
            rb = EXP_W'($urandom) & EXP_W'((64'd1 << $urandom_range(0, EXP_W)) - 1);
            run_op($sformatf("rnd%0d", i), rand_a(), rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
